// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus of the RV64 front end: instruction memory port, branch
// redirect input and the IF/ID valid/ready slot toward the decoder.
interface instruction_fetch_unit_if;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        id_ready;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        halted;
    logic        misaligned_fault;

    modport master (
        output Inst_Address,
        input  Instruction,
        input  branch_taken,
        input  branch_target,
        input  id_ready,
        output id_valid,
        output id_pc,
        output id_instruction,
        output halted,
        output misaligned_fault
    );

    modport slave (
        input  Inst_Address,
        output Instruction,
        output branch_taken,
        output branch_target,
        output id_ready,
        input  id_valid,
        input  id_pc,
        input  id_instruction,
        input  halted,
        input  misaligned_fault
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV64 instruction fetch: PC register, IF/ID capture slot with valid/ready
// handoff, branch redirect, misaligned-target fault and end-of-memory halt.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 16,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master bus
);

    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

    logic [63:0] pc;
    logic        slot_free;
    logic        in_range;

    assign slot_free        = !bus.id_valid || bus.id_ready;
    assign in_range         = (pc <= LAST_PC);
    assign bus.Inst_Address = pc;

    // Priority chain: fault freeze, bad redirect, redirect, halt, capture, stall.
    // Whenever the slot empties, id_instruction is forced back to NOP_WORD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                   <= RESET_PC;
            bus.id_valid         <= 1'b0;
            bus.id_pc            <= 64'd0;
            bus.id_instruction   <= NOP_WORD;
            bus.halted           <= 1'b0;
            bus.misaligned_fault <= 1'b0;
        end else if (bus.misaligned_fault) begin
            if (bus.id_ready) begin
                bus.id_valid <= 1'b0;
            end
        end else if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
            bus.misaligned_fault <= 1'b1;
            bus.halted           <= 1'b1;
            bus.id_valid         <= 1'b0;
            bus.id_instruction   <= NOP_WORD;
        end else if (bus.branch_taken) begin
            pc                 <= bus.branch_target;
            bus.id_valid       <= 1'b0;
            bus.id_instruction <= NOP_WORD;
            bus.halted         <= 1'b0;
        end else if (bus.halted || !in_range) begin
            bus.halted <= 1'b1;
            if (bus.id_ready) begin
                bus.id_valid       <= 1'b0;
                bus.id_instruction <= NOP_WORD;
            end
        end else if (slot_free) begin
            bus.id_pc          <= pc;
            bus.id_instruction <= bus.Instruction;
            bus.id_valid       <= 1'b1;
            pc                 <= pc + 64'd4;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a scoreboard of expected
// (pc, word) pairs is drained by a monitor on every decoder handoff.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          tests = 0;
    int          failures = 0;
    fetch_t      expected_q[$];
    logic [31:0] mem [4] = '{32'h0285_3483, 32'h009A_84B3, 32'h0014_8493, 32'h0295_3423};

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC (64'd0),
        .MEM_BYTES(16),
        .NOP_WORD (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.Instruction = (bus.Inst_Address < 64'd16) ? mem[bus.Inst_Address[3:2]] : 32'h0000_0000;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic taken, input logic [63:0] target, input logic ready);
        bus.branch_taken  = taken;
        bus.branch_target = target;
        bus.id_ready      = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [63:0] pc, input logic [31:0] instr);
        fetch_t e;
        e.pc    = pc;
        e.instr = instr;
        expected_q.push_back(e);
    endtask

    // A handoff happens on the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && bus.id_valid && bus.id_ready) begin
            checkOutput("sb_entry_available", 64'(expected_q.size() != 0), 64'd1);
            if (expected_q.size() != 0) begin
                fetch_t e;
                e = expected_q.pop_front();
                checkOutput("sb_id_pc", bus.id_pc, e.pc);
                checkOutput("sb_id_instruction", 64'(bus.id_instruction), 64'(e.instr));
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        tick();

        checkOutput("rst_id_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("rst_id_pc", bus.id_pc, 64'd0);
        checkOutput("rst_id_instruction", 64'(bus.id_instruction), 64'(NOP));
        checkOutput("rst_halted", 64'(bus.halted), 64'd0);
        checkOutput("rst_fault", 64'(bus.misaligned_fault), 64'd0);
        checkOutput("rst_inst_address", bus.Inst_Address, 64'd0);

        // Straight-line fetch to end of memory
        for (int i = 0; i < 4; i++) push_expected(64'(4 * i), mem[i]);
        reset = 1'b0;
        tick();
        checkOutput("first_valid", 64'(bus.id_valid), 64'd1);
        checkOutput("first_pc", bus.id_pc, 64'd0);
        tick();
        tick();
        tick();
        checkOutput("last_pc", bus.id_pc, 64'd12);
        checkOutput("not_yet_halted", 64'(bus.halted), 64'd0);
        tick();
        checkOutput("end_halted", 64'(bus.halted), 64'd1);
        checkOutput("end_valid_drop", 64'(bus.id_valid), 64'd0);
        checkOutput("end_nop", 64'(bus.id_instruction), 64'(NOP));
        checkOutput("end_inst_address", bus.Inst_Address, 64'd16);
        tick();
        checkOutput("end_still_halted", 64'(bus.halted), 64'd1);
        checkOutput("end_still_empty", 64'(bus.id_valid), 64'd0);

        // Restart from halt with an aligned branch to 0
        applyStimulus(1'b1, 64'd0, 1'b1);
        push_expected(64'd0, mem[0]);
        push_expected(64'd4, mem[1]);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("restart_halted", 64'(bus.halted), 64'd0);
        checkOutput("restart_bubble", 64'(bus.id_valid), 64'd0);
        checkOutput("restart_address", bus.Inst_Address, 64'd0);
        tick();
        checkOutput("restart_pc", bus.id_pc, 64'd0);
        checkOutput("restart_instr", 64'(bus.id_instruction), 64'(mem[0]));
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0);

        // Stall with pc=4 in the slot
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_valid", 64'(bus.id_valid), 64'd1);
            checkOutput("stall_pc", bus.id_pc, 64'd4);
            checkOutput("stall_instr", 64'(bus.id_instruction), 64'(mem[1]));
            checkOutput("stall_address", bus.Inst_Address, 64'd8);
        end
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOutput("release_pc", bus.id_pc, 64'd8);
        checkOutput("release_instr", 64'(bus.id_instruction), 64'(mem[2]));

        // Redirect to 4 while the pc=8 slot is stalled
        applyStimulus(1'b1, 64'd4, 1'b0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("redirect_flush", 64'(bus.id_valid), 64'd0);
        checkOutput("redirect_nop", 64'(bus.id_instruction), 64'(NOP));
        checkOutput("redirect_address", bus.Inst_Address, 64'd4);
        push_expected(64'd4, mem[1]);
        tick();
        checkOutput("redirect_capture_valid", 64'(bus.id_valid), 64'd1);
        checkOutput("redirect_capture_pc", bus.id_pc, 64'd4);

        // Misaligned target faults and freezes fetch
        applyStimulus(1'b1, 64'd6, 1'b1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1);
        checkOutput("fault_set", 64'(bus.misaligned_fault), 64'd1);
        checkOutput("fault_halted", 64'(bus.halted), 64'd1);
        checkOutput("fault_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("fault_pc_held", bus.Inst_Address, 64'd8);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("fault_frozen_valid", 64'(bus.id_valid), 64'd0);
            checkOutput("fault_frozen_address", bus.Inst_Address, 64'd8);
        end
        checkOutput("fault_sticky", 64'(bus.misaligned_fault), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("fault_cleared", 64'(bus.misaligned_fault), 64'd0);
        checkOutput("fault_halt_cleared", 64'(bus.halted), 64'd0);
        tick();

        // Reset asserted mid-stall acts without a clock edge
        applyStimulus(1'b0, 64'd0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        checkOutput("prestall_valid", 64'(bus.id_valid), 64'd1);
        checkOutput("prestall_pc", bus.id_pc, 64'd0);
        checkOutput("prestall_address", bus.Inst_Address, 64'd4);
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 64'(bus.id_valid), 64'd0);
        checkOutput("async_instr", 64'(bus.id_instruction), 64'(NOP));
        checkOutput("async_pc", bus.id_pc, 64'd0);
        checkOutput("async_address", bus.Inst_Address, 64'd0);
        tick();

        for (int i = 0; i < 4; i++) push_expected(64'(4 * i), mem[i]);
        applyStimulus(1'b0, 64'd0, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rerun_pc", bus.id_pc, 64'(4 * i));
        end
        tick();
        checkOutput("rerun_halted", 64'(bus.halted), 64'd1);
        tick();
        checkOutput("sb_drained", 64'(expected_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
